// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory/I-O bridge.
//   IO_BASE        : first I/O word address; everything below is RAM
//   IO_*_OFS       : register offsets from IO_BASE
//   rsel_e         : registered read-select state encoding
//   STAT_*         : status word bit positions
//   make_status()  : packs full/empty/count into the status word
package cpu_pkg;

    localparam logic [15:0] IO_BASE     = 16'hFF00;
    localparam logic [15:0] IO_DATA_OFS = 16'd0;
    localparam logic [15:0] IO_STAT_OFS = 16'd1;

    localparam int STAT_FULL_BIT  = 15;
    localparam int STAT_EMPTY_BIT = 14;
    localparam int STAT_CNT_W     = 8;

    typedef enum logic [1:0] {
        RSEL_NONE = 2'd0,
        RSEL_RAM  = 2'd1,
        RSEL_STAT = 2'd2,
        RSEL_ZERO = 2'd3
    } rsel_e;

    function automatic logic [15:0] make_status(input logic        full,
                                                input logic        empty,
                                                input logic [15:0] cnt);
        logic [15:0] s;
        s                      = '0;
        s[STAT_FULL_BIT]       = full;
        s[STAT_EMPTY_BIT]      = empty;
        s[STAT_CNT_W-1:0]      = cnt[STAT_CNT_W-1:0];
        return s;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Circular word FIFO feeding the output stream.
//   CLK, reset : clock, synchronous active-high reset
//   push       : request to enqueue wdata (accepted if not full, or if a pop
//                frees a slot in the same cycle)
//   wdata      : word to enqueue
//   pop_req    : downstream accept; only pops when the FIFO holds data
//   rdata      : current head word
//   count      : occupancy, 0..DEPTH
//   full/empty : occupancy flags
module io_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       push,
    input  logic [15:0]                wdata,
    input  logic                       pop_req,
    output logic [15:0]                rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign empty = (count == CW'(0));
    assign full  = (count == CW'(DEPTH));
    assign rdata = mem[rptr];

    // A pop on a full FIFO frees the slot the push needs, so both proceed.
    // An empty FIFO never pops, so a push into it cannot bypass.
    assign do_pop  = pop_req & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (!reset && do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/mem_io_bridge.sv
// CPU-side bridge splitting a 16-bit word address space into RAM and a small
// I/O window at IO_BASE: IO_DATA (write pushes into the output FIFO) and
// IO_STAT (read returns full/empty/count).
//   CLK, reset           : clock, synchronous active-high reset
//   MemRead, MemWrite    : CPU strobes (both high = write only)
//   ADDR, WData          : CPU word address and write data
//   RData                : read data, valid the cycle after MemRead
//   stall                : CPU must hold its request while high
//   ram_re/we/addr/wdata : RAM request, combinational from the CPU side
//   ram_rdata            : RAM data, valid the cycle after ram_re
//   out_data, out_valid  : output stream head
//   out_ready            : downstream accept
module mem_io_bridge
    import cpu_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] IO_BASE    = cpu_pkg::IO_BASE
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] ADDR,
    input  logic [15:0] WData,
    output logic [15:0] RData,
    output logic        stall,
    output logic        ram_re,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          ram_hit, data_hit, stat_hit;
    logic          rd;
    logic          push;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic [15:0]   stat_q;
    logic [15:0]   rdata_q;
    logic [15:0]   rdata_mux;
    rsel_e         rsel_q, rsel_d;

    // Address decode
    assign ram_hit  = (ADDR <  IO_BASE);
    assign data_hit = (ADDR == IO_BASE + IO_DATA_OFS);
    assign stat_hit = (ADDR == IO_BASE + IO_STAT_OFS);

    // A simultaneous read and write is treated as a write only.
    assign rd = MemRead & ~MemWrite;

    assign ram_re    = rd & ram_hit;
    assign ram_we    = MemWrite & ram_hit;
    assign ram_addr  = ADDR;
    assign ram_wdata = WData;

    // Only a full FIFO with no drain this cycle blocks the CPU.
    assign stall = MemWrite & data_hit & fifo_full & ~out_ready;
    assign push  = MemWrite & data_hit & ~stall;

    io_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK     (CLK),
        .reset   (reset),
        .push    (push),
        .wdata   (WData),
        .pop_req (out_ready),
        .rdata   (out_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = ~fifo_empty;

    // Read-select state machine: records what the current read targets so
    // the following cycle knows which source drives RData.
    always_ff @(posedge CLK) begin
        if (reset) rsel_q <= RSEL_NONE;
        else       rsel_q <= rsel_d;
    end

    always_comb begin
        rsel_d = RSEL_NONE;
        if (rd) begin
            if (ram_hit)       rsel_d = RSEL_RAM;
            else if (stat_hit) rsel_d = RSEL_STAT;
            else               rsel_d = RSEL_ZERO;
        end
    end

    // Status is sampled in the read cycle, not the cycle the data returns.
    always_ff @(posedge CLK) begin
        if (reset)
            stat_q <= '0;
        else if (rd && stat_hit)
            stat_q <= make_status(fifo_full, fifo_empty, 16'(fifo_count));
    end

    // RAM data arrives registered from the RAM itself, so the select mux
    // feeds RData directly and rdata_q keeps the last value for idle cycles.
    always_comb begin
        rdata_mux = rdata_q;
        case (rsel_q)
            RSEL_RAM:  rdata_mux = ram_rdata;
            RSEL_STAT: rdata_mux = stat_q;
            RSEL_ZERO: rdata_mux = '0;
            default:   rdata_mux = rdata_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) rdata_q <= '0;
        else       rdata_q <= rdata_mux;
    end

    assign RData = rdata_mux;

endmodule

// File: tb/tb_mem_io_bridge.sv
module tb_mem_io_bridge;

    logic        CLK = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [15:0] ADDR, WData;
    logic [15:0] RData;
    logic        stall;
    logic        ram_re, ram_we;
    logic [15:0] ram_addr, ram_wdata;
    logic [15:0] ram_rdata = 16'h0000;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int total = 0;
    int fails = 0;

    logic [15:0] tb_ram [256];

    always #5 CLK = ~CLK;

    mem_io_bridge #(.FIFO_DEPTH(4), .IO_BASE(16'hFF00)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ADDR      (ADDR),
        .WData     (WData),
        .RData     (RData),
        .stall     (stall),
        .ram_re    (ram_re),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Simple synchronous RAM: data one cycle after ram_re.
    always @(posedge CLK) begin
        if (ram_we) tb_ram[ram_addr[7:0]] <= ram_wdata;
        if (ram_re) ram_rdata <= tb_ram[ram_addr[7:0]];
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ADDR     = 16'h0000;
        WData    = 16'h0000;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        MemRead  = 1'b0;
        MemWrite = 1'b1;
        ADDR     = a;
        WData    = d;
    endtask

    task automatic rd(input logic [15:0] a);
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        ADDR     = a;
        WData    = 16'h0000;
    endtask

    initial begin
        idle();
        out_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_rdata", RData, 16'h0000);
        chk("rst_stall", 16'(stall), 16'h0);
        chk("rst_ram_strobes", 16'({ram_re, ram_we}), 16'h0);

        // RAM write then read
        wr(16'h0010, 16'h1234);
        #1;
        chk("ram_we_on_write", 16'(ram_we), 16'h1);
        chk("ram_re_on_write", 16'(ram_re), 16'h0);
        chk("ram_addr", ram_addr, 16'h0010);
        chk("ram_wdata", ram_wdata, 16'h1234);
        tick();
        rd(16'h0010);
        #1;
        chk("ram_re_on_read", 16'(ram_re), 16'h1);
        chk("ram_we_after_pulse", 16'(ram_we), 16'h0);
        tick();
        idle();
        #1;
        chk("ram_rdata_1cyc", RData, 16'h1234);
        tick();
        chk("rdata_hold", RData, 16'h1234);

        // Read+write together is a write only
        MemRead = 1'b1; MemWrite = 1'b1; ADDR = 16'h0020; WData = 16'h5555;
        #1;
        chk("rw_both_strobes", 16'({ram_re, ram_we}), 16'h1);
        tick();
        rd(16'h0020);
        tick();
        idle();
        #1;
        chk("rw_both_written", RData, 16'h5555);

        // Fill the FIFO with the downstream blocked
        for (int i = 0; i < 4; i++) begin
            wr(16'hFF00, 16'h00A1 + 16'(i));
            #1;
            chk("fill_no_stall", 16'(stall), 16'h0);
            tick();
        end
        wr(16'hFF00, 16'h00A5);
        #1;
        chk("full_stall", 16'(stall), 16'h1);
        chk("full_valid", 16'(out_valid), 16'h1);
        chk("full_head", out_data, 16'h00A1);
        tick();
        rd(16'hFF01);
        tick();
        idle();
        #1;
        chk("stat_full", RData, 16'h8004);

        // Simultaneous push and pop while full
        wr(16'hFF00, 16'h00A5);
        out_ready = 1'b1;
        #1;
        chk("full_pushpop_no_stall", 16'(stall), 16'h0);
        tick();
        out_ready = 1'b0;
        idle();
        #1;
        chk("after_pushpop_head", out_data, 16'h00A2);
        rd(16'hFF01);
        tick();
        idle();
        #1;
        chk("after_pushpop_stat", RData, 16'h8004);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_valid", 16'(out_valid), 16'h1);
            chk("drain_order", out_data, 16'h00A2 + 16'(k));
            tick();
        end
        chk("drained_empty", 16'(out_valid), 16'h0);

        // Streaming with pointer wrap
        for (int i = 0; i < 10; i++) begin
            wr(16'hFF00, 16'h00B0 + 16'(i));
            #1;
            chk("stream_no_stall", 16'(stall), 16'h0);
            if (i > 0) chk("stream_order", out_data, 16'h00B0 + 16'(i - 1));
            tick();
        end
        idle();
        #1;
        chk("stream_last_valid", 16'(out_valid), 16'h1);
        chk("stream_last", out_data, 16'h00B9);
        tick();
        chk("stream_empty", 16'(out_valid), 16'h0);
        out_ready = 1'b0;
        rd(16'hFF01);
        tick();
        idle();
        #1;
        chk("stream_stat", RData, 16'h4000);

        // Unmapped read, writes to STAT and unmapped dropped
        wr(16'hFF00, 16'h00C1);
        tick();
        rd(16'hFF07);
        tick();
        idle();
        #1;
        chk("unmapped_read_zero", RData, 16'h0000);
        wr(16'hFF01, 16'hFFFF);
        #1;
        chk("stat_write_no_stall", 16'(stall), 16'h0);
        chk("stat_write_no_ram", 16'(ram_we), 16'h0);
        tick();
        wr(16'hFF05, 16'hEEEE);
        #1;
        chk("unmapped_write_no_stall", 16'(stall), 16'h0);
        tick();
        rd(16'hFF01);
        tick();
        idle();
        #1;
        chk("dropped_writes_stat", RData, 16'h0001);
        chk("dropped_writes_head", out_data, 16'h00C1);

        // Reset mid-stream, with a push pending during reset
        wr(16'hFF00, 16'h00C2);
        tick();
        wr(16'hFF00, 16'h00C3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        #1;
        chk("midrst_valid", 16'(out_valid), 16'h0);
        chk("midrst_rdata", RData, 16'h0000);
        rd(16'hFF01);
        tick();
        idle();
        #1;
        chk("midrst_stat", RData, 16'h4000);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 The block SHALL take parameter FIFO_DEPTH, default 4, as the output FIFO depth in words, a power of two, minimum 2.
REQ-002 The block SHALL take parameter IO_BASE, default 16'hFF00, as the first I/O address; RAM occupies every address below it.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock, all state on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous and active-high.
REQ-005 The block SHALL have port MemRead, input, 1 bit: CPU read strobe.
REQ-006 The block SHALL have port MemWrite, input, 1 bit: CPU write strobe.
REQ-007 The block SHALL have port ADDR, input, 16 bits: CPU word address.
REQ-008 The block SHALL have port WData, input, 16 bits: CPU write data.
REQ-009 The block SHALL have port RData, output, 16 bits: registered read data to the CPU.
REQ-010 The block SHALL have port stall, output, 1 bit: CPU must hold its strobes, ADDR and WData while high.
REQ-011 The block SHALL have ports ram_re and ram_we, outputs, 1 bit each: RAM strobes.
REQ-012 The block SHALL have ports ram_addr and ram_wdata, outputs, 16 bits each: RAM address and write data.
REQ-013 The block SHALL have port ram_rdata, input, 16 bits: RAM read data, valid one cycle after ram_re.
REQ-014 The block SHALL have ports out_data, output, 16 bits, and out_valid, output, 1 bit: the output stream head.
REQ-015 The block SHALL have port out_ready, input, 1 bit: downstream accept.

Function
REQ-016 The block SHALL decode the address as follows: ADDR < IO_BASE is RAM, ADDR == IO_BASE is IO_DATA, ADDR == IO_BASE+1 is IO_STAT, and any other address at or above IO_BASE is unmapped.
REQ-017 The block SHALL treat a cycle with MemRead and MemWrite both high as a write only.
REQ-018 The block SHALL drive ram_re = MemRead & ~MemWrite & RAM hit, and ram_we = MemWrite & RAM hit, combinationally; ram_addr SHALL equal ADDR and ram_wdata SHALL equal WData.
REQ-019 The block SHALL use a registered read-select state machine with states NONE, RAM, STAT and ZERO, loaded every cycle from the decode of the current read; with no read it SHALL load NONE.
REQ-020 RData SHALL be valid exactly one cycle after MemRead, selected as follows: RAM gives ram_rdata; STAT gives the status word captured at the read cycle; ZERO (IO_DATA or unmapped read) gives 0; NONE holds the previous RData.
REQ-021 The status word SHALL be: bit15 = full, bit14 = empty, bits[7:0] = FIFO count zero-extended, all other bits 0.
REQ-022 A write to IO_DATA SHALL push WData into the circular FIFO; the write and read pointers SHALL wrap modulo FIFO_DEPTH, and count SHALL range from 0 to FIFO_DEPTH.
REQ-023 out_valid SHALL be (count != 0) and out_data SHALL be the FIFO head; a pop SHALL occur when out_valid & out_ready.
REQ-024 A push into an empty FIFO SHALL make out_valid high on the next cycle; data SHALL never bypass the FIFO combinationally.
REQ-025 stall SHALL equal MemWrite & IO_DATA hit & full & ~out_ready, combinationally; a stalled write SHALL NOT push.
REQ-026 When the FIFO is full, a push and a pop in the same cycle SHALL both occur, count SHALL be unchanged, and stall SHALL be low.
REQ-027 When the FIFO is empty and a push occurs, no pop SHALL occur that cycle.
REQ-028 Writes to IO_STAT and to unmapped addresses SHALL be dropped silently, with no stall.
REQ-029 FIFO order SHALL be strict first-in first-out; no word SHALL be lost or duplicated.

Reset
REQ-030 While reset is high at a clock edge, the block SHALL clear both pointers and count, set RData to 0, set the select state to NONE, and suppress any push or pop that cycle.
REQ-031 After reset, out_valid SHALL be 0; stall, ram_re and ram_we SHALL follow their combinational definitions; a reset mid-stream SHALL discard all queued words.

Structure
REQ-032 The shared package cpu_pkg SHALL hold IO_BASE, the IO_DATA and IO_STAT offsets, the read-select state encoding, and the status bit positions.
REQ-033 The FIFO SHALL be a single sub-module io_fifo, holding the storage, pointers, count, full and empty; the bridge SHALL hold the decode, the read-select state machine and the RData register.

Verification
REQ-034 Reset, then RAM write to 0x0010 with 0x1234, then MemRead 0x0010 -> ram_we pulses one cycle; RData = 0x1234 one cycle after the read.
REQ-035 With out_ready=0, write 0xA1, 0xA2, 0xA3, 0xA4 to IO_DATA, then a fifth write of 0xA5 -> stall high on the fifth write; reading IO_STAT gives 0x8004.
REQ-036 In the full state, raise out_ready for one cycle with the 0xA5 write pending -> 0xA1 popped, 0xA5 pushed, stall low, count stays 4, output order then A2, A3, A4, A5.
REQ-037 With out_ready=1, do 10 back-to-back IO_DATA writes (exercising pointer wrap) -> all 10 words out in order, no stall, final IO_STAT = 0x4000.
REQ-038 MemRead to 0xFF07 and MemWrite to IO_STAT -> RData = 0, FIFO count unchanged, no stall.
REQ-039 Push 2 words, assert reset for one cycle -> out_valid = 0 next cycle and IO_STAT = 0x4000.
